// File: rtl/mnist_class_argmax_pkg.sv
// ============================================================================
// Module   : mnist_class_argmax_pkg
// Purpose  : Shared defaults and width helpers for the MNIST class scoring
//            stage (class count, channel multiplexing, label/user widths).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mnist_class_argmax_pkg;

    localparam int c_DEF_CLASS_NUM   = 10;
    localparam int c_DEF_CHANNEL_NUM = 1;
    localparam int c_DEF_USER_WIDTH  = 8;
    localparam int c_DEF_LABEL_WIDTH = 8;
    localparam int c_DEF_CNT_WIDTH   = 32;

    // Ceiling log2, usable in constant expressions (value <= 2^30).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // Width able to hold a popcount of channel_num votes (0..channel_num).
    function automatic int sum_width(input int channel_num);
        return clog2(channel_num + 1);
    endfunction

    // Width of a class index; at least one bit even for a single class.
    function automatic int class_width(input int class_num);
        return (class_num > 1) ? clog2(class_num) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mnist_class_argmax_popcount.sv
// ============================================================================
// Module   : mnist_class_argmax_popcount
// Purpose  : Combinational popcount of the per-channel votes of one class.
// Ports    : votes - CHANNEL_NUM binary votes for one class
//            sum   - number of votes set
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mnist_class_argmax_popcount
    import mnist_class_argmax_pkg::*;
#(
    parameter int CHANNEL_NUM = c_DEF_CHANNEL_NUM
) (
    input  logic [CHANNEL_NUM-1:0]             votes,
    output logic [sum_width(CHANNEL_NUM)-1:0]  sum
);

    localparam int c_SUM_WIDTH = sum_width(CHANNEL_NUM);

    always_comb begin
        sum = '0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            sum = sum + c_SUM_WIDTH'(votes[i]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/mnist_class_argmax.sv
// ============================================================================
// Module   : mnist_class_argmax
// Purpose  : Scores the per-class binary votes of the MNIST LUT network:
//            popcount per class, argmax (ties -> lowest index), label compare
//            and running per-frame total/correct statistics.
// Ports    : clk, reset (sync, active-high), cke (global clock enable)
//            in_user/in_last/in_data/in_valid   - input sample, no backpressure
//            out_user/out_last/out_valid        - side-band delayed by 2 stages
//            out_class/out_score/out_none       - argmax result
//            out_match                          - winner equals carried label
//            stat_total/stat_ok/stat_done       - frame statistics
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mnist_class_argmax
    import mnist_class_argmax_pkg::*;
#(
    parameter int CLASS_NUM   = c_DEF_CLASS_NUM,
    parameter int CHANNEL_NUM = c_DEF_CHANNEL_NUM,
    parameter int USER_WIDTH  = c_DEF_USER_WIDTH,
    parameter int LABEL_WIDTH = c_DEF_LABEL_WIDTH,
    parameter int CNT_WIDTH   = c_DEF_CNT_WIDTH
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                cke,
    input  logic [USER_WIDTH-1:0]               in_user,
    input  logic                                in_last,
    input  logic [CLASS_NUM*CHANNEL_NUM-1:0]    in_data,
    input  logic                                in_valid,
    output logic [USER_WIDTH-1:0]               out_user,
    output logic                                out_last,
    output logic [class_width(CLASS_NUM)-1:0]   out_class,
    output logic [sum_width(CHANNEL_NUM)-1:0]   out_score,
    output logic                                out_none,
    output logic                                out_match,
    output logic                                out_valid,
    output logic [CNT_WIDTH-1:0]                stat_total,
    output logic [CNT_WIDTH-1:0]                stat_ok,
    output logic                                stat_done
);

    localparam int c_SUM_WIDTH   = sum_width(CHANNEL_NUM);
    localparam int c_CLASS_WIDTH = class_width(CLASS_NUM);

    // ------------------------------------------------------------------
    // Per-class popcount. Vote bit for (channel ch, class cls) sits at
    // in_data[ch*CLASS_NUM + cls].
    // ------------------------------------------------------------------
    logic [c_SUM_WIDTH-1:0] w_sum [CLASS_NUM];

    for (genvar g_cls = 0; g_cls < CLASS_NUM; g_cls++) begin : g_class
        logic [CHANNEL_NUM-1:0] w_votes;

        for (genvar g_ch = 0; g_ch < CHANNEL_NUM; g_ch++) begin : g_chan
            assign w_votes[g_ch] = in_data[g_ch*CLASS_NUM + g_cls];
        end

        mnist_class_argmax_popcount #(
            .CHANNEL_NUM (CHANNEL_NUM)
        ) u_popcount (
            .votes (w_votes),
            .sum   (w_sum[g_cls])
        );
    end

    // ------------------------------------------------------------------
    // Stage 1: class sums and side-band. Data is registered even when
    // invalid so the datapath carries no valid-based gating.
    // ------------------------------------------------------------------
    logic [c_SUM_WIDTH-1:0] r_s1_sum [CLASS_NUM];
    logic [USER_WIDTH-1:0]  r_s1_user;
    logic                   r_s1_last;
    logic                   r_s1_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CLASS_NUM; i++) begin
                r_s1_sum[i] <= '0;
            end
            r_s1_user  <= '0;
            r_s1_last  <= 1'b0;
            r_s1_valid <= 1'b0;
        end else if (cke) begin
            for (int i = 0; i < CLASS_NUM; i++) begin
                r_s1_sum[i] <= w_sum[i];
            end
            r_s1_user  <= in_user;
            r_s1_last  <= in_last;
            r_s1_valid <= in_valid;
        end
    end

    // ------------------------------------------------------------------
    // Argmax: linear compare chain. Strict '>' keeps the lowest index on
    // ties, and leaves the index at 0 when every sum is zero.
    // ------------------------------------------------------------------
    logic [c_SUM_WIDTH-1:0]   w_best_score;
    logic [c_CLASS_WIDTH-1:0] w_best_idx;
    logic [LABEL_WIDTH-1:0]   w_label;
    logic                     w_none;
    logic                     w_match;

    assign w_label = r_s1_user[LABEL_WIDTH-1:0];

    always_comb begin
        w_best_score = r_s1_sum[0];
        w_best_idx   = '0;
        for (int i = 1; i < CLASS_NUM; i++) begin
            if (r_s1_sum[i] > w_best_score) begin
                w_best_score = r_s1_sum[i];
                w_best_idx   = c_CLASS_WIDTH'(i);
            end
        end
        w_none  = (w_best_score == '0);
        // Compared at 32 bits so a label wider than the class index (i.e.
        // >= CLASS_NUM) can never alias onto a valid class.
        w_match = !w_none && (32'(w_label) == 32'(w_best_idx));
    end

    // ------------------------------------------------------------------
    // Stage 2: result registers.
    // ------------------------------------------------------------------
    logic [USER_WIDTH-1:0]    r_out_user;
    logic                     r_out_last;
    logic [c_CLASS_WIDTH-1:0] r_out_class;
    logic [c_SUM_WIDTH-1:0]   r_out_score;
    logic                     r_out_none;
    logic                     r_out_match;
    logic                     r_out_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_user  <= '0;
            r_out_last  <= 1'b0;
            r_out_class <= '0;
            r_out_score <= '0;
            r_out_none  <= 1'b0;
            r_out_match <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (cke) begin
            r_out_user  <= r_s1_user;
            r_out_last  <= r_s1_last;
            r_out_class <= w_best_idx;
            r_out_score <= w_best_score;
            r_out_none  <= w_none;
            r_out_match <= w_match;
            r_out_valid <= r_s1_valid;
        end
    end

    // ------------------------------------------------------------------
    // Frame statistics, updated on the edge that registers a valid result.
    // A finished frame (done=1) is held until the next valid sample, which
    // restarts the counters at that sample.
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] r_stat_total;
    logic [CNT_WIDTH-1:0] r_stat_ok;
    logic                 r_stat_done;
    logic [CNT_WIDTH-1:0] w_total_inc;
    logic [CNT_WIDTH-1:0] w_ok_inc;

    // Saturating increments: counters stick at all-ones.
    assign w_total_inc = (r_stat_total == '1) ? r_stat_total : r_stat_total + CNT_WIDTH'(1);
    assign w_ok_inc    = (r_stat_ok    == '1) ? r_stat_ok    : r_stat_ok    + CNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_total <= '0;
            r_stat_ok    <= '0;
            r_stat_done  <= 1'b0;
        end else if (cke && r_s1_valid) begin
            if (r_stat_done) begin
                r_stat_total <= CNT_WIDTH'(1);
                r_stat_ok    <= CNT_WIDTH'(w_match);
            end else begin
                r_stat_total <= w_total_inc;
                if (w_match) begin
                    r_stat_ok <= w_ok_inc;
                end
            end
            r_stat_done <= r_s1_last;
        end
    end

    assign out_user   = r_out_user;
    assign out_last   = r_out_last;
    assign out_class  = r_out_class;
    assign out_score  = r_out_score;
    assign out_none   = r_out_none;
    assign out_match  = r_out_match;
    assign out_valid  = r_out_valid;
    assign stat_total = r_stat_total;
    assign stat_ok    = r_stat_ok;
    assign stat_done  = r_stat_done;

endmodule

`default_nettype wire

// File: tb/tb_mnist_class_argmax.sv
// ============================================================================
// Module   : tb_mnist_class_argmax
// Purpose  : Self-checking bench for mnist_class_argmax. Two instances share
//            the stimulus: a 32-bit counter build and a 4-bit counter build
//            that exercises counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mnist_class_argmax;

    localparam int     CLASS_NUM   = 10;
    localparam int     CHANNEL_NUM = 4;
    localparam int     USER_WIDTH  = 8;
    localparam int     LABEL_WIDTH = 6;
    localparam int     CNT_WIDTH   = 32;
    localparam int     SAT_WIDTH   = 4;
    localparam int     DW          = CLASS_NUM * CHANNEL_NUM;
    localparam int     N_SEQ       = 10000;
    localparam longint MAX32       = 64'h0000_0000_FFFF_FFFF;
    localparam longint MAX_SAT     = 15;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  cke;
    logic [USER_WIDTH-1:0] in_user;
    logic                  in_last;
    logic [DW-1:0]         in_data;
    logic                  in_valid;

    logic [USER_WIDTH-1:0] out_user;
    logic                  out_last;
    logic [3:0]            out_class;
    logic [2:0]            out_score;
    logic                  out_none;
    logic                  out_match;
    logic                  out_valid;
    logic [CNT_WIDTH-1:0]  stat_total;
    logic [CNT_WIDTH-1:0]  stat_ok;
    logic                  stat_done;

    logic [USER_WIDTH-1:0] s_out_user;
    logic                  s_out_last;
    logic [3:0]            s_out_class;
    logic [2:0]            s_out_score;
    logic                  s_out_none;
    logic                  s_out_match;
    logic                  s_out_valid;
    logic [SAT_WIDTH-1:0]  s_stat_total;
    logic [SAT_WIDTH-1:0]  s_stat_ok;
    logic                  s_stat_done;

    int n_checks = 0;
    int n_errors = 0;

    mnist_class_argmax #(
        .CLASS_NUM(CLASS_NUM), .CHANNEL_NUM(CHANNEL_NUM), .USER_WIDTH(USER_WIDTH),
        .LABEL_WIDTH(LABEL_WIDTH), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .reset(reset), .cke(cke),
        .in_user(in_user), .in_last(in_last), .in_data(in_data), .in_valid(in_valid),
        .out_user(out_user), .out_last(out_last), .out_class(out_class),
        .out_score(out_score), .out_none(out_none), .out_match(out_match),
        .out_valid(out_valid), .stat_total(stat_total), .stat_ok(stat_ok),
        .stat_done(stat_done)
    );

    mnist_class_argmax #(
        .CLASS_NUM(CLASS_NUM), .CHANNEL_NUM(CHANNEL_NUM), .USER_WIDTH(USER_WIDTH),
        .LABEL_WIDTH(LABEL_WIDTH), .CNT_WIDTH(SAT_WIDTH)
    ) dut_sat (
        .clk(clk), .reset(reset), .cke(cke),
        .in_user(in_user), .in_last(in_last), .in_data(in_data), .in_valid(in_valid),
        .out_user(s_out_user), .out_last(s_out_last), .out_class(s_out_class),
        .out_score(s_out_score), .out_none(s_out_none), .out_match(s_out_match),
        .out_valid(s_out_valid), .stat_total(s_stat_total), .stat_ok(s_stat_ok),
        .stat_done(s_stat_done)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    // Reference scoring of one sample: count the votes of each class, keep
    // the first class reaching the highest count.
    function automatic void predict(input logic [DW-1:0] d, input logic [USER_WIDTH-1:0] u,
                                    output int cls, output int score,
                                    output bit none, output bit match);
        int cnt;
        cls   = 0;
        score = 0;
        for (int c = 0; c < CLASS_NUM; c++) begin
            cnt = 0;
            for (int ch = 0; ch < CHANNEL_NUM; ch++) begin
                cnt += int'(d[ch*CLASS_NUM + c]);
            end
            if (cnt > score) begin
                score = cnt;
                cls   = c;
            end
        end
        none  = (score == 0);
        match = !none && (int'(u[LABEL_WIDTH-1:0]) == cls);
    endfunction

    // ------------------------------------------------------------------
    // Model state: the sample captured at the last enabled edge (p_*),
    // the result the outputs must show (e_*), and the two stat sets.
    // ------------------------------------------------------------------
    bit                    m_ok = 1'b0;
    bit                    p_valid, p_last;
    logic [DW-1:0]         p_data;
    logic [USER_WIDTH-1:0] p_user;
    bit                    e_valid, e_last, e_none, e_match;
    logic [USER_WIDTH-1:0] e_user;
    int                    e_class, e_score;
    longint                t32, o32, t4, o4;
    bit                    d32, d4;
    int                    mc, ms;
    bit                    mn, mm;

    // Compare process: at each falling edge, check the DUT against the
    // model, then advance the model with the inputs the next rising edge
    // will sample (inputs only change just after rising edges).
    initial begin
        forever begin
            @(negedge clk);
            if (m_ok) begin
                chk("out_valid", out_valid, e_valid);
                chk("sat_out_valid", s_out_valid, e_valid);
                if (e_valid) begin
                    chk("out_user",  out_user,  e_user);
                    chk("out_last",  out_last,  e_last);
                    chk("out_class", out_class, e_class);
                    chk("out_score", out_score, e_score);
                    chk("out_none",  out_none,  e_none);
                    chk("out_match", out_match, e_match);
                    chk("sat_out_class", s_out_class, e_class);
                end
                chk("stat_total", stat_total, t32);
                chk("stat_ok",    stat_ok,    o32);
                chk("stat_done",  stat_done,  d32);
                chk("sat_stat_total", s_stat_total, t4);
                chk("sat_stat_ok",    s_stat_ok,    o4);
                chk("sat_stat_done",  s_stat_done,  d4);
            end
            if (reset) begin
                m_ok    = 1'b1;
                p_valid = 0; p_last = 0; p_data = '0; p_user = '0;
                e_valid = 0; e_last = 0; e_none = 0; e_match = 0;
                e_user  = '0; e_class = 0; e_score = 0;
                t32 = 0; o32 = 0; d32 = 0;
                t4  = 0; o4  = 0; d4  = 0;
            end else if (cke && m_ok) begin
                predict(p_data, p_user, mc, ms, mn, mm);
                e_valid = p_valid; e_last = p_last; e_user = p_user;
                e_class = mc; e_score = ms; e_none = mn; e_match = mm;
                if (p_valid) begin
                    if (d32) begin t32 = 1; o32 = longint'(mm); end
                    else begin t32 = sat(t32 + 1, MAX32); o32 = sat(o32 + longint'(mm), MAX32); end
                    d32 = p_last;
                    if (d4) begin t4 = 1; o4 = longint'(mm); end
                    else begin t4 = sat(t4 + 1, MAX_SAT); o4 = sat(o4 + longint'(mm), MAX_SAT); end
                    d4 = p_last;
                end
                p_valid = in_valid; p_last = in_last; p_data = in_data; p_user = in_user;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [DW-1:0]         seq_data [N_SEQ];
    logic [USER_WIDTH-1:0] seq_user [N_SEQ];

    task automatic step(input logic v, input logic [DW-1:0] d, input logic [USER_WIDTH-1:0] u,
                        input logic l, input logic ce, input logic rst);
        @(posedge clk);
        #1;
        in_valid = v; in_data = d; in_user = u; in_last = l; cke = ce; reset = rst;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, DW'({$urandom(), $urandom()}), USER_WIDTH'($urandom()), 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic run_seq(input bit rand_cke);
        for (int i = 0; i < N_SEQ; i++) begin
            bit ce;
            int tries;
            tries = 0;
            do begin
                ce = rand_cke ? ((($urandom() & 1) != 0) || (tries >= 8)) : 1'b1;
                step(1'b1, seq_data[i], seq_user[i], (i == N_SEQ-1), ce, 1'b0);
                tries++;
            end while (!ce);
        end
    endtask

    initial begin
        reset = 1'b1; cke = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        in_data = '0; in_user = '0;

        // Sequence for the long runs: nonzero votes, label = winner on even
        // samples, a wrong class or an out-of-range label on odd samples.
        for (int i = 0; i < N_SEQ; i++) begin
            logic [DW-1:0] d;
            logic [5:0]    lab;
            int c, s;
            bit n, m;
            d = DW'({$urandom(), $urandom()});
            if (d == '0) d[i % DW] = 1'b1;
            predict(d, '0, c, s, n, m);
            if (i % 2 == 0)      lab = 6'(c);
            else if (i % 4 == 1) lab = 6'(10 + $urandom_range(0, 53));
            else                 lab = 6'((c + 1 + $urandom_range(0, 8)) % 10);
            seq_data[i] = d;
            seq_user[i] = {2'($urandom()), lab};
        end

        repeat (3) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        idle(2);
        chk("reset_out_valid",  out_valid,  0);
        chk("reset_stat_total", stat_total, 0);
        chk("reset_stat_done",  stat_done,  0);

        // 1: single class-3 vote, label 3, one-sample frame
        step(1'b1, DW'(40'h00_0000_0008), 8'h03, 1'b1, 1'b1, 1'b0);
        idle(2);
        chk("t1_valid", out_valid, 1);
        chk("t1_class", out_class, 3);
        chk("t1_match", out_match, 1);
        chk("t1_score", out_score, 1);
        chk("t1_total", stat_total, 1);
        chk("t1_ok",    stat_ok,    1);
        chk("t1_done",  stat_done,  1);

        // 2: classes 2 and 7 tie at 3 votes -> class 2; label 7 misses
        step(1'b1, (DW'(1) << 2) | (DW'(1) << 12) | (DW'(1) << 22) |
                   (DW'(1) << 7) | (DW'(1) << 17) | (DW'(1) << 27),
             8'h07, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk("t2_class", out_class, 2);
        chk("t2_score", out_score, 3);
        chk("t2_match", out_match, 0);
        chk("t2_total", stat_total, 1);
        chk("t2_ok",    stat_ok,    0);

        // 3: no votes, label 0 -> none, no match, total still counts
        step(1'b1, '0, 8'h00, 1'b1, 1'b1, 1'b0);
        idle(2);
        chk("t3_none",  out_none,   1);
        chk("t3_class", out_class,  0);
        chk("t3_match", out_match,  0);
        chk("t3_total", stat_total, 2);
        chk("t3_ok",    stat_ok,    0);
        chk("t3_done",  stat_done,  1);

        // Bits above the label field are ignored: user 0xC5 -> label 5
        step(1'b1, DW'(1) << 5, 8'hC5, 1'b1, 1'b1, 1'b0);
        idle(2);
        chk("t3b_match", out_match, 1);
        chk("t3b_user",  out_user,  8'hC5);
        chk("t3b_total", stat_total, 1);

        // 4: back-to-back frame of N_SEQ samples
        run_seq(1'b0);
        idle(2);
        chk("t4_total", stat_total, N_SEQ);
        chk("t4_ok",    stat_ok,    N_SEQ / 2);
        chk("t4_done",  stat_done,  1);
        chk("t4_sat_total", s_stat_total, 15);
        chk("t4_sat_ok",    s_stat_ok,    15);

        step(1'b1, seq_data[0], seq_user[0], 1'b0, 1'b1, 1'b0);
        idle(2);
        chk("t4b_total", stat_total, 1);
        chk("t4b_ok",    stat_ok,    1);
        chk("t4b_done",  stat_done,  0);

        step(1'b1, seq_data[1], seq_user[1], 1'b1, 1'b1, 1'b0);
        idle(2);
        chk("t4c_total", stat_total, 2);

        // 5: same frame with cke toggled randomly
        run_seq(1'b1);
        idle(2);
        chk("t5_total", stat_total, N_SEQ);
        chk("t5_ok",    stat_ok,    N_SEQ / 2);
        chk("t5_done",  stat_done,  1);

        // 6: reset (with cke low) while samples are in flight
        step(1'b1, seq_data[2], seq_user[2], 1'b0, 1'b1, 1'b0);
        step(1'b1, seq_data[3], seq_user[3], 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("t6_valid",  out_valid,  0);
        chk("t6_total",  stat_total, 0);
        chk("t6_ok",     stat_ok,    0);
        chk("t6_done",   stat_done,  0);
        idle(3);
        chk("t6_valid_late", out_valid, 0);
        step(1'b1, seq_data[4], seq_user[4], 1'b1, 1'b1, 1'b0);
        idle(2);
        chk("t6_new_valid", out_valid,  1);
        chk("t6_new_total", stat_total, 1);
        chk("t6_new_ok",    stat_ok,    1);
        chk("t6_new_done",  stat_done,  1);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
